// File: rtl/sprite_palette_mapper.sv
// Sprite colour stage: ROM index fetch, banked palette lookup, transparency and
// timed hit-flash override, registered RGB output with 2-cycle latency.
module sprite_palette_mapper #(
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned IDX_W        = 3,
  parameter int unsigned NUM_PAL      = 2,
  parameter int unsigned TRANSP_IDX   = 0,
  parameter int unsigned FLASH_FRAMES = 6,
  localparam int unsigned PalSelW     = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               pix_valid_in,
  input  logic [ADDR_W-1:0]  address,
  input  logic [PalSelW-1:0] pal_sel,
  input  logic               frame_start,
  input  logic               flash_trig,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [IDX_W-1:0]   rom_data,
  input  logic               pal_we,
  input  logic [PalSelW-1:0] pal_wbank,
  input  logic [IDX_W-1:0]   pal_widx,
  input  logic [23:0]        pal_wdata,
  output logic [7:0]         Red,
  output logic [7:0]         Green,
  output logic [7:0]         Blue,
  output logic               zero,
  output logic               pix_valid_out,
  output logic               flash_active
);

  localparam int unsigned        Entries   = 2 ** IDX_W;
  localparam logic [PalSelW:0]   NumPalV   = (PalSelW + 1)'(NUM_PAL);
  localparam logic [IDX_W-1:0]   TranspV   = IDX_W'(TRANSP_IDX);
  localparam logic [7:0]         FlashLoad = 8'(FLASH_FRAMES);
  localparam logic [23:0]        White     = 24'hFFFFFF;

  logic [23:0]        pal_q [NUM_PAL][Entries];
  logic [PalSelW-1:0] act_bank_q, act_bank_d;
  logic [7:0]         flash_cnt_q, flash_cnt_d;
  logic               v1_q;
  logic [23:0]        rgb_q, rgb_d;
  logic               zero_q, zero_d;
  logic               pix_valid_q;
  logic               wbank_ok, sel_ok;
  logic [23:0]        entry;

  // S0: the ROM sees the request address directly.
  assign rom_addr = address;

  assign wbank_ok = ({1'b0, pal_wbank} < NumPalV);
  assign sel_ok   = ({1'b0, pal_sel} < NumPalV);

  // Palette store; a same-cycle lookup sees the pre-write value.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int b = 0; b < int'(NUM_PAL); b++) begin
        for (int e = 0; e < int'(Entries); e++) begin
          pal_q[b][e] <= 24'h000000;
        end
      end
    end else if (pal_we && wbank_ok) begin
      pal_q[pal_wbank][pal_widx] <= pal_wdata;
    end
  end

  // Bank only changes on a frame boundary so a frame never mixes palettes.
  always_comb begin
    act_bank_d = act_bank_q;
    if (frame_start && sel_ok) begin
      act_bank_d = pal_sel;
    end
  end

  // A trigger wins over a coincident frame_start so the flash lasts full frames.
  always_comb begin
    flash_cnt_d = flash_cnt_q;
    if (flash_trig) begin
      flash_cnt_d = FlashLoad;
    end else if (frame_start && (flash_cnt_q != 8'd0)) begin
      flash_cnt_d = flash_cnt_q - 8'd1;
    end
  end

  assign flash_active = (flash_cnt_q != 8'd0);

  // S1: resolve the ROM index against the active bank.
  always_comb begin
    entry  = pal_q[act_bank_q][rom_data];
    rgb_d  = rgb_q;
    zero_d = zero_q;
    if (v1_q) begin
      if (rom_data == TranspV) begin
        zero_d = 1'b1;
        rgb_d  = White;
      end else if (flash_active) begin
        zero_d = 1'b0;
        rgb_d  = White;
      end else begin
        zero_d = 1'b0;
        rgb_d  = entry;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      act_bank_q  <= '0;
      flash_cnt_q <= 8'd0;
      v1_q        <= 1'b0;
      rgb_q       <= 24'h000000;
      zero_q      <= 1'b1;
      pix_valid_q <= 1'b0;
    end else begin
      act_bank_q  <= act_bank_d;
      flash_cnt_q <= flash_cnt_d;
      v1_q        <= pix_valid_in;
      rgb_q       <= rgb_d;
      zero_q      <= zero_d;
      pix_valid_q <= v1_q;
    end
  end

  assign Red           = rgb_q[23:16];
  assign Green         = rgb_q[15:8];
  assign Blue          = rgb_q[7:0];
  assign zero          = zero_q;
  assign pix_valid_out = pix_valid_q;

endmodule

// File: tb/tb_sprite_palette_mapper.sv
// Directed and random checks of sprite_palette_mapper against a frame-level
// reference model (NUM_PAL=3, FLASH_FRAMES=2).
module tb_sprite_palette_mapper;

  localparam int AW = 19;
  localparam int IW = 3;
  localparam int NP = 3;
  localparam int FF = 2;
  localparam int SW = 2;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          pix_valid_in;
  logic [AW-1:0] address;
  logic [SW-1:0] pal_sel;
  logic          frame_start;
  logic          flash_trig;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_data;
  logic          pal_we;
  logic [SW-1:0] pal_wbank;
  logic [IW-1:0] pal_widx;
  logic [23:0]   pal_wdata;
  logic [7:0]    Red, Green, Blue;
  logic          zero, pix_valid_out, flash_active;

  int checks = 0;
  int errors = 0;

  sprite_palette_mapper #(
    .ADDR_W(AW), .IDX_W(IW), .NUM_PAL(NP), .TRANSP_IDX(0), .FLASH_FRAMES(FF)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pix_valid_in(pix_valid_in), .address(address),
    .pal_sel(pal_sel), .frame_start(frame_start), .flash_trig(flash_trig),
    .rom_addr(rom_addr), .rom_data(rom_data), .pal_we(pal_we), .pal_wbank(pal_wbank),
    .pal_widx(pal_widx), .pal_wdata(pal_wdata), .Red(Red), .Green(Green), .Blue(Blue),
    .zero(zero), .pix_valid_out(pix_valid_out), .flash_active(flash_active)
  );

  always #5 Clk = ~Clk;

  // Sprite ROM: colour index is the low address bits, one cycle late.
  always @(posedge Clk) rom_data <= rom_addr[IW-1:0];

  // Reference model state
  logic [23:0] m_pal [NP][8];
  int          m_bank, m_flash, m_idx1;
  bit          m_v1, m_pvo, m_zero;
  logic [23:0] m_rgb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NP; b++) for (int e = 0; e < 8; e++) m_pal[b][e] = 24'h0;
    m_bank = 0; m_flash = 0; m_v1 = 0; m_idx1 = 0;
    m_pvo = 0; m_zero = 1; m_rgb = 24'h0;
  endtask

  // Advance model with pre-edge inputs, clock DUT once, compare everything.
  task automatic tick();
    if (Reset) begin
      model_reset();
    end else begin
      m_pvo = m_v1;
      if (m_v1) begin
        if (m_idx1 == 0) begin m_zero = 1; m_rgb = 24'hFFFFFF; end
        else if (m_flash > 0) begin m_zero = 0; m_rgb = 24'hFFFFFF; end
        else begin m_zero = 0; m_rgb = m_pal[m_bank][m_idx1]; end
      end
      m_v1   = pix_valid_in;
      m_idx1 = int'(address % 8);
      if (pal_we && int'(pal_wbank) < NP) m_pal[pal_wbank][pal_widx] = pal_wdata;
      if (frame_start && int'(pal_sel) < NP) m_bank = int'(pal_sel);
      if (flash_trig) m_flash = FF;
      else if (frame_start && m_flash > 0) m_flash = m_flash - 1;
    end
    @(posedge Clk);
    #1;
    chk("rgb", {8'h0, Red, Green, Blue}, {8'h0, m_rgb});
    chk("zero", 32'(zero), 32'(m_zero));
    chk("pix_valid_out", 32'(pix_valid_out), 32'(m_pvo));
    chk("flash_active", 32'(flash_active), 32'(m_flash > 0));
    chk("rom_addr", 32'(rom_addr), 32'(address));
  endtask

  task automatic idle();
    pix_valid_in = 0; frame_start = 0; flash_trig = 0; pal_we = 0;
  endtask

  task automatic wr(input int bank, input int idx, input logic [23:0] data);
    pal_we = 1; pal_wbank = SW'(bank); pal_widx = IW'(idx); pal_wdata = data;
    tick();
    pal_we = 0;
  endtask

  // Issue one request then one idle cycle so the result is on the outputs.
  task automatic px(input int idx);
    pix_valid_in = 1; address = AW'($urandom) & ~AW'(7) | AW'(idx);
    tick();
    pix_valid_in = 0;
    tick();
  endtask

  task automatic pulse_frame();
    frame_start = 1; tick(); frame_start = 0;
  endtask

  initial begin
    Reset = 1; idle(); address = '0; pal_sel = '0; pal_wbank = '0; pal_widx = '0;
    pal_wdata = '0;
    model_reset();
    tick(); tick();
    chk("reset_rgb", {8'h0, Red, Green, Blue}, 32'h0);
    chk("reset_zero", 32'(zero), 32'd1);
    chk("reset_pvo", 32'(pix_valid_out), 32'd0);
    Reset = 0;

    // Basic lookup
    wr(0, 2, 24'h2B82CA);
    px(2);
    chk("basic_rgb", {8'h0, Red, Green, Blue}, 32'h2B82CA);
    chk("basic_zero", 32'(zero), 32'd0);
    px(0);
    chk("transp_rgb", {8'h0, Red, Green, Blue}, 32'hFFFFFF);
    chk("transp_zero", 32'(zero), 32'd1);
    tick();
    chk("invalid_pvo", 32'(pix_valid_out), 32'd0);
    chk("hold_zero", 32'(zero), 32'd1);

    // Bank switching only on frame_start
    wr(1, 2, 24'h112233);
    pal_sel = 1;
    px(2);
    chk("midframe_sel", {8'h0, Red, Green, Blue}, 32'h2B82CA);
    pulse_frame();
    px(2);
    chk("bank1", {8'h0, Red, Green, Blue}, 32'h112233);
    pal_sel = 3;
    pulse_frame();
    px(2);
    chk("sel_oob", {8'h0, Red, Green, Blue}, 32'h112233);

    // Hit flash
    flash_trig = 1; tick(); flash_trig = 0;
    chk("flash_on", 32'(flash_active), 32'd1);
    px(2);
    chk("flash_rgb", {8'h0, Red, Green, Blue}, 32'hFFFFFF);
    chk("flash_zero", 32'(zero), 32'd0);
    px(0);
    chk("flash_transp", 32'(zero), 32'd1);
    pulse_frame();
    chk("flash_f1", 32'(flash_active), 32'd1);
    pulse_frame();
    chk("flash_f2", 32'(flash_active), 32'd0);
    px(2);
    chk("flash_end", {8'h0, Red, Green, Blue}, 32'h112233);
    flash_trig = 1; frame_start = 1; tick(); flash_trig = 0; frame_start = 0;
    pulse_frame();
    chk("coinc_f1", 32'(flash_active), 32'd1);
    pulse_frame();
    chk("coinc_f2", 32'(flash_active), 32'd0);

    // Same-cycle write/read of [0][2]
    pal_sel = 0;
    pulse_frame();
    pix_valid_in = 1; address = AW'(2); tick();
    pal_we = 1; pal_wbank = 0; pal_widx = 2; pal_wdata = 24'hABCDEF; tick();
    pal_we = 0;
    chk("wr_old", {8'h0, Red, Green, Blue}, 32'h2B82CA);
    pix_valid_in = 0; tick();
    chk("wr_new", {8'h0, Red, Green, Blue}, 32'hABCDEF);
    wr(3, 2, 24'h555555);
    px(2);
    chk("wbank_oob0", {8'h0, Red, Green, Blue}, 32'hABCDEF);
    pal_sel = 2;
    pulse_frame();
    px(2);
    chk("wbank_oob2", {8'h0, Red, Green, Blue}, 32'h000000);

    // Reset with pixels in flight
    flash_trig = 1; pix_valid_in = 1; address = AW'(2); tick();
    flash_trig = 0; address = AW'(3); tick();
    Reset = 1; tick(); Reset = 0; pix_valid_in = 0;
    chk("rst_pvo", 32'(pix_valid_out), 32'd0);
    chk("rst_rgb", {8'h0, Red, Green, Blue}, 32'h0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_flash", 32'(flash_active), 32'd0);
    px(2);
    chk("rst_pal", {8'h0, Red, Green, Blue}, 32'h000000);
    chk("rst_pal_zero", 32'(zero), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      Reset        = ($urandom_range(0, 199) == 0);
      pix_valid_in = ($urandom_range(0, 3) != 0);
      address      = AW'($urandom);
      pal_sel      = SW'($urandom_range(0, 3));
      frame_start  = ($urandom_range(0, 9) == 0);
      flash_trig   = ($urandom_range(0, 29) == 0);
      pal_we       = ($urandom_range(0, 4) == 0);
      pal_wbank    = SW'($urandom_range(0, 3));
      pal_widx     = IW'($urandom);
      pal_wdata    = 24'($urandom);
      tick();
    end
    Reset = 0; idle();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
